// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the byte-wide instruction fetch path.
// Holds the sequencer state encoding and the word geometry.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int PC_INCR        = 4;
  localparam int CNT_W          = 2;

  // True when the byte counter points at the most significant byte of the word.
  function automatic logic is_last_byte(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(BYTES_PER_WORD - 1));
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_byte_assembler.sv
// Little-endian 32-bit word register filled one byte at a time.
// A byte lands in the lane selected by the fetch byte counter.
module byte_assembler
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_capture,
  input  logic [CNT_W-1:0] i_byte_cnt,
  input  logic [7:0]       i_data,
  output logic [31:0]      o_word
);

  logic [31:0] r_word;

  // Word register: synchronous clear wins, otherwise write the addressed lane.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_word <= 32'h0000_0000;
    end else if (i_capture) begin
      case (i_byte_cnt)
        2'd0:    r_word[7:0]   <= i_data;
        2'd1:    r_word[15:8]  <= i_data;
        2'd2:    r_word[23:16] <= i_data;
        2'd3:    r_word[31:24] <= i_data;
        default: r_word        <= r_word;
      endcase
    end else begin
      r_word <= r_word;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: four byte reads per word, valid/ready hand-off
// to decode, and ownership of the program counter including redirects.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_data,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] pc_out
);

  fetch_state_e      r_state;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [ADDR_W-1:0] r_pc;

  logic              w_capture;
  logic              w_clr;
  logic [31:0]       w_word;

  // A byte arriving in the same cycle as a redirect belongs to the old stream.
  assign w_capture = (r_state == ST_FETCH) && mem_ready && !pc_load;
  assign w_clr     = !rst_n;

  // Sequencer state, byte counter and program counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= {CNT_W{1'b0}};
      r_pc       <= RESET_PC;
    end else if (pc_load) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= {CNT_W{1'b0}};
      r_pc       <= pc_load_val;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_byte_cnt <= {CNT_W{1'b0}};
          r_pc       <= r_pc;
          r_state    <= halt ? ST_IDLE : ST_FETCH;
        end
        ST_FETCH: begin
          r_pc <= r_pc;
          if (mem_ready) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            r_state    <= is_last_byte(r_byte_cnt) ? ST_HOLD : ST_FETCH;
          end else begin
            r_byte_cnt <= r_byte_cnt;
            r_state    <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          r_byte_cnt <= {CNT_W{1'b0}};
          if (instr_ready) begin
            r_pc    <= r_pc + ADDR_W'(PC_INCR);
            r_state <= ST_IDLE;
          end else begin
            r_pc    <= r_pc;
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_byte_cnt <= {CNT_W{1'b0}};
          r_pc       <= r_pc;
        end
      endcase
    end
  end

  byte_assembler u_byte_assembler (
    .clk        (clk),
    .i_clr      (w_clr),
    .i_capture  (w_capture),
    .i_byte_cnt (r_byte_cnt),
    .i_data     (mem_data),
    .o_word     (w_word)
  );

  assign mem_rd      = (r_state == ST_FETCH);
  assign mem_addr    = r_pc + {{(ADDR_W-CNT_W){1'b0}}, r_byte_cnt};
  assign instr_valid = (r_state == ST_HOLD);
  assign instr_out   = w_word;
  assign pc_out      = r_pc;

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Sequencer for the byte-wide instruction fetch path: it issues four consecutive byte reads from instruction memory, assembles them into one 32-bit instruction word, and offers the word to decode with a valid/ready handshake. It owns the program counter, so it also handles PC advance and redirect (branch/jump) requests. It sits between instruction memory and the decode stage and replaces free-running, event-driven instruction assembly with a clocked, counted sequence.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, default 32: width of the PC and memory address.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active-low, sampled on the `clk` rising edge.
- `halt` in 1: while high in IDLE, no new fetch starts.
- `mem_rd` out 1: byte read request.
- `mem_addr` out ADDR_W: byte address, equal to PC + byte_cnt.
- `mem_ready` in 1: memory returns `mem_data` this cycle for the current `mem_addr`.
- `mem_data` in 8: read byte.
- `instr_out` out 32: assembled instruction.
- `instr_valid` out 1: `instr_out` holds a complete word.
- `instr_ready` in 1: decode accepts the word.
- `pc_load` in 1: redirect request.
- `pc_load_val` in ADDR_W: redirect target.
- `pc_out` out ADDR_W: address of the word being fetched or held.

## Operation
- The states are IDLE, FETCH and HOLD.
- **IDLE**
  - `mem_rd`=0.
  - Goes to FETCH next cycle when `halt`=0; stays in IDLE otherwise.
- **FETCH**
  - `mem_rd`=1 and `mem_addr`=PC+byte_cnt.
  - On each edge with `mem_ready`=1, `mem_data` is written to `instr_out[8*byte_cnt+7 : 8*byte_cnt]` (little-endian: byte at PC lands in bits [7:0]) and byte_cnt increments.
  - On the capture of byte 3, byte_cnt wraps to 0 and the state goes to HOLD.
  - `mem_ready`=0 stalls: no capture and the address is held.
- **HOLD**
  - `instr_valid`=1, `mem_rd`=0.
  - `instr_out` and `pc_out` are stable until accepted.
  - On an edge with `instr_valid`&&`instr_ready`: PC ← PC+4 (modulo 2^ADDR_W, wraps silently), then to IDLE.
- `instr_valid` is high only in HOLD.
- **Redirect:** `pc_load`=1 has priority in every state.
  - PC ← `pc_load_val`, byte_cnt ← 0, state ← IDLE.
  - Any partial word and any held word are discarded; `instr_out` is not cleared.
  - A byte presented with `mem_ready` in the same cycle is dropped.
- **Redirect during a handshake:** if `pc_load` coincides with `instr_valid`&&`instr_ready`, the transfer counts as completed and PC takes `pc_load_val`, not PC+4.
- `pc_load_val` is not alignment-checked; unaligned targets fetch PC..PC+3 as-is.
- **Reset** (`rst_n`=0 at an edge) applies from any state, mid-fetch included:
  - state=IDLE, PC=`RESET_PC`, byte_cnt=0, `instr_out`=0.
  - Giving outputs `mem_rd`=0, `mem_addr`=`RESET_PC`, `instr_valid`=0, `pc_out`=`RESET_PC`.

## Timing
- `mem_rd`, `mem_addr` and `instr_valid` are combinational decodes of registered state, byte_cnt and PC; no input-to-output combinational path.
- With `mem_ready` tied to 1 and `halt`=0, the sequence after reset release is:
  - cycle 0: IDLE.
  - cycles 1–4: FETCH, addresses PC..PC+3.
  - cycle 5: HOLD, `instr_valid`=1.
- Best-case throughput is one instruction per 6 cycles with `instr_ready` held high; accept-to-next-`mem_rd` latency is 1 cycle through IDLE.
- `pc_load` takes effect at the edge it is sampled; `mem_rd` is 0 in the following cycle.
- Decode must not see `instr_out` change while `instr_valid`=1.

## Structure
- Shared package `fetch_pkg`:
  - state enum (IDLE, FETCH, HOLD).
  - `BYTES_PER_WORD`=4.
  - `PC_INCR`=4.
- One sub-module, `byte_assembler`:
  - Inputs: byte_cnt, capture enable, `mem_data`, synchronous clear.
  - Owns the 32-bit word register.
- The controller keeps the FSM, byte_cnt and PC.

## Test plan
- **Reset, then straight fetch.** Memory at 0..3 holds 8'h13, 8'h05, 8'h10, 8'h00; `mem_ready`=1.
  - Required: `instr_out`=32'h0010_0513 with `instr_valid` in cycle 5.
  - Required: `mem_addr` sequence 0, 1, 2, 3.
- **Memory wait states.** `mem_ready` low for 2 cycles before byte 2.
  - Required: `mem_addr` holds at PC+2 and `instr_valid` arrives 2 cycles late.
  - Required: word unchanged versus the straight-fetch case.
- **Decode backpressure.** `instr_ready`=0 for 5 cycles.
  - Required: `instr_valid`, `instr_out` and `pc_out` stable and `mem_rd`=0.
  - Required: after acceptance, next `mem_addr`=PC+4.
- **Redirect mid-fetch.** `pc_load`=1 with `pc_load_val`=32'h40 after 2 bytes captured.
  - Required: next fetch addresses 0x40..0x43.
  - Required: the partial word never appears with `instr_valid`.
- **Redirect coincident with accept.**
  - Required: exactly one transfer counted and PC=`pc_load_val`, not PC+4.
- **Reset mid-fetch and PC wrap.**
  - `rst_n`=0 during FETCH → outputs return to their reset values next cycle.
  - PC=32'hFFFF_FFFC accepted → PC=0.
